// File: rtl/ex_mem_wb_pipe_pkg.sv
// Shared CPU pipeline types for the EX/MEM and MEM/WB stage registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: register-index width, zero-register index, and packed structs
// for the two stage registers. XLEN fixes the datapath width of the structs.
package ex_mem_wb_pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;
  localparam int XLEN = 64;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] rw;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  sdata;
  } ex_mem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [REG_W-1:0] rw;
    logic [XLEN-1:0]  wbdata;
  } mem_wb_t;

endpackage

// File: rtl/ex_mem_wb_pipe_pipe_reg.sv
// Generic pipeline stage register with hold and clear.
// Latency: 1 cycle from i_d to o_q.
// Backpressure: i_hold freezes contents; hold wins over i_clear.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (clears to 0)
//   i_hold         keep current contents this edge
//   i_clear        capture all-zero instead of i_d (bubble)
//   i_d / o_q      W-bit data in / registered data out
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_hold,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_clear ? '0 : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB stage registers, data-memory drive, writeback select, retire counter.
// Latency: 1 edge EX->EX/MEM, 2 edges EX->MEM/WB; memory read data is sampled combinationally.
// Backpressure: stall freezes both stages and the counter; flush inserts a bubble into EX/MEM.
// Ports:
//   clk, reset          clock; asynchronous active-high reset clears all state
//   stall, flush        freeze both stages / bubble into EX/MEM (stall has priority)
//   ex_*                instruction fields from the EX stage
//   mem_*               data-memory address, write data, enables, read data
//   EX_MEM_*, MEM_WB_*  forwarding / hazard / register-file write outputs
//   retire_count        instructions retired since reset (wraps)
// Build option: define FWD_ZERO_REG_EN to suppress RegWrite for destination X31.
// DATA_W must equal the package XLEN.
module ex_mem_wb_pipe
  import ex_mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_RegWrite,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  input  logic              ex_MemToReg,
  input  logic [REG_W-1:0]  ex_Rw,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemRead,
  output logic [REG_W-1:0]  EX_MEM_Rw,
  output logic [DATA_W-1:0] EX_MEM_fwd_data,
  output logic              MEM_WB_RegWrite,
  output logic [REG_W-1:0]  MEM_WB_Rw,
  output logic [DATA_W-1:0] MEM_WB_fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  ex_mem_t w_ex_mem_d;
  ex_mem_t w_ex_mem_q;
  mem_wb_t w_mem_wb_d;
  mem_wb_t w_mem_wb_q;
  logic    w_em_wr_ok;
  logic    w_wb_wr_ok;

  logic [CNT_W-1:0] r_retire_count;

  assign w_ex_mem_d = '{
    valid:      ex_valid,
    reg_write:  ex_RegWrite,
    mem_read:   ex_MemRead,
    mem_write:  ex_MemWrite,
    mem_to_reg: ex_MemToReg,
    rw:         ex_Rw,
    alu:        ex_alu_result,
    sdata:      ex_store_data
  };

  // Flush clears the whole stage, so control bits and valid all drop together.
  pipe_reg #(.W($bits(ex_mem_t))) u_ex_mem (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_hold  (stall),
    .i_clear (flush),
    .i_d     (w_ex_mem_d),
    .o_q     (w_ex_mem_q)
  );

  // Load data is selected here, in the same cycle mem_re is asserted.
  assign w_mem_wb_d = '{
    valid:     w_ex_mem_q.valid,
    reg_write: w_ex_mem_q.reg_write,
    rw:        w_ex_mem_q.rw,
    wbdata:    w_ex_mem_q.mem_to_reg ? mem_rdata : w_ex_mem_q.alu
  };

  pipe_reg #(.W($bits(mem_wb_t))) u_mem_wb (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_hold  (stall),
    .i_clear (1'b0),
    .i_d     (w_mem_wb_d),
    .o_q     (w_mem_wb_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_count <= '0;
    end else if (!stall && w_mem_wb_q.valid) begin
      r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef FWD_ZERO_REG_EN
  // X31 is the zero register: never forward it and never write it back.
  assign w_em_wr_ok = (w_ex_mem_q.rw != XZR);
  assign w_wb_wr_ok = (w_mem_wb_q.rw != XZR);
`else
  assign w_em_wr_ok = 1'b1;
  assign w_wb_wr_ok = 1'b1;
`endif

  // A stalled store must not write: the same store is re-presented next cycle.
  assign mem_we          = w_ex_mem_q.valid & w_ex_mem_q.mem_write & ~stall;
  assign mem_re          = w_ex_mem_q.valid & w_ex_mem_q.mem_read;
  assign mem_addr        = w_ex_mem_q.alu;
  assign mem_wdata       = w_ex_mem_q.sdata;

  assign EX_MEM_RegWrite = w_ex_mem_q.valid & w_ex_mem_q.reg_write & w_em_wr_ok;
  assign EX_MEM_MemRead  = w_ex_mem_q.valid & w_ex_mem_q.mem_read;
  assign EX_MEM_Rw       = w_ex_mem_q.rw;
  assign EX_MEM_fwd_data = w_ex_mem_q.alu;

  assign MEM_WB_RegWrite = w_mem_wb_q.valid & w_mem_wb_q.reg_write & w_wb_wr_ok;
  assign MEM_WB_Rw       = w_mem_wb_q.rw;
  assign MEM_WB_fwd_data = w_mem_wb_q.wbdata;

  assign retire_count    = r_retire_count;

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Pipeline registers between the EX stage and writeback: the EX/MEM and MEM/WB stage registers, plus the data-memory interface drive and writeback data select.
- Directly upstream of the forwarding unit. It sources the EX_MEM_RegWrite, MEM_WB_RegWrite, EX_MEM_Rw and MEM_WB_Rw signals that unit compares against ID/EX source registers, and the matching forward data.
- Handles stall (freeze), flush (bubble insert) and a retired-instruction counter.

Parameters:
DATA_W, 64, width of ALU result, store data, load data, writeback data
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
stall  in  1  freeze both stage registers this cycle
flush  in  1  capture a bubble into EX/MEM instead of the EX instruction
ex_valid  in  1  EX stage holds a real instruction
ex_RegWrite  in  1  instruction writes the register file
ex_MemRead  in  1  load
ex_MemWrite  in  1  store
ex_MemToReg  in  1  writeback selects load data
ex_Rw  in  5  destination register
ex_alu_result  in  DATA_W  ALU output / memory address
ex_store_data  in  DATA_W  store data
mem_addr  out  DATA_W  data-memory address (EX/MEM alu result)
mem_wdata  out  DATA_W  data-memory write data
mem_we  out  1  data-memory write enable
mem_re  out  1  data-memory read enable
mem_rdata  in  DATA_W  data-memory read data, valid same cycle as mem_re
EX_MEM_RegWrite  out  1  to forwarding unit
EX_MEM_MemRead  out  1  to hazard unit (load-use detect)
EX_MEM_Rw  out  5  to forwarding unit
EX_MEM_fwd_data  out  DATA_W  EX/MEM alu result (ForwardA/B = 10 source)
MEM_WB_RegWrite  out  1  to forwarding unit and register-file write enable
MEM_WB_Rw  out  5  to forwarding unit and register-file write address
MEM_WB_fwd_data  out  DATA_W  writeback data (ForwardA/B = 01 source)
retire_count  out  CNT_W  instructions retired since reset

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - Reset asynchronous active-high: all valid bits, control bits, Rw fields, data fields and retire_count go to 0 immediately. All outputs read 0 while reset is high.
- Stage registers: EX/MEM = {valid, RegWrite, MemRead, MemWrite, MemToReg, Rw, alu, sdata}; MEM/WB = {valid, RegWrite, Rw, wbdata}.
- Normal cycle (stall=0, flush=0):
  - EX/MEM <= EX inputs.
  - MEM/WB <= EX/MEM, with wbdata = MemToReg ? mem_rdata : alu.
  - One-cycle latency per stage; EX inputs reach MEM_WB_* two edges later.
- flush=1, stall=0: EX/MEM.valid <= 0 and all EX/MEM control bits <= 0; data fields don't-care. MEM/WB advances normally.
- stall=1: both stage registers hold and retire_count holds. stall has priority over flush; upstream keeps flush asserted until stall drops.
- Combinational outputs:
  - Every control output is gated by its stage valid: EX_MEM_RegWrite = v1 & RegWrite; MEM_WB_RegWrite = v2 & RegWrite.
  - mem_we = v1 & MemWrite & ~stall.
  - mem_re = v1 & MemRead.
  - mem_addr = alu; mem_wdata = sdata.
- retire_count: +1 on each edge where MEM/WB.valid=1 and stall=0. Wraps modulo 2^CNT_W silently.
- ex_MemRead and ex_MemWrite both high: illegal, no checking required. Store takes effect; load data is still captured.
- Reset deasserted mid-stream: first valid instruction appears at MEM_WB two edges after it is presented.

Optional Feature:
- Macro: FWD_ZERO_REG_EN.
- Defined: EX_MEM_RegWrite and MEM_WB_RegWrite are forced 0 when the corresponding Rw == 5'd31 (XZR). Writes to X31 are never forwarded and never reach the register file. retire_count is unaffected.
- Undefined: Rw 31 is treated like any other register; the register file is responsible for ignoring X31.

Decomposition:
- Shared CPU package holds:
  - REG_W = 5 and XZR = 5'd31 constants
  - packed struct typedef ex_mem_t for the EX/MEM fields
  - packed struct typedef mem_wb_t for the MEM/WB fields
- One sub-module, pipe_reg: a generic width-parameterised register with async reset, hold (stall) and clear (flush) inputs. Instantiated twice, once with clear tied 0 for MEM/WB.

Test Plan:
- Reset mid-run with both stages valid -> all outputs 0 same cycle, retire_count=0; after release, first instruction appears at MEM_WB two edges later.
- ALU op Rw=5, alu=0x1234, RegWrite=1 -> cycle+1: EX_MEM_RegWrite=1, Rw=5, fwd=0x1234; cycle+2: MEM_WB_RegWrite=1, Rw=5, fwd=0x1234; retire_count 0->1.
- Load Rw=3, MemToReg=1, addr=0x40, mem_rdata=0xDEAD -> cycle+1: mem_re=1, mem_addr=0x40, EX_MEM_MemRead=1; cycle+2: MEM_WB_fwd_data=0xDEAD.
- Store in EX/MEM with stall=1 for 3 cycles -> mem_we=0 during stall, stage contents and retire_count unchanged; mem_we=1 exactly one cycle after stall drops.
- flush=1 with ex_RegWrite=1 -> EX/MEM bubble, EX_MEM_RegWrite=0 next cycle, no retire increment two cycles later; flush+stall together -> hold, no bubble.
- With FWD_ZERO_REG_EN: ALU op Rw=31 -> EX_MEM_RegWrite=0 and MEM_WB_RegWrite=0, retire_count still increments. Without the macro: both =1.
